eth_axis_pkt_fifo: RTL and testbench
====================================

ETH_AXIS_PKT_FIFO -- requirements
Module: eth_axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 64, tdata width in bits; tkeep width DataWidth/8.
REQ-002 SHALL have parameter UserWidth, default 1, tuser width; tuser[0] is the frame-error flag.
REQ-003 SHALL have parameter Depth, default 512, beat capacity; power of two, >= 4.
REQ-004 SHALL have parameter StoreForward, default 1; 1 = store-and-forward mode, 0 = cut-through mode.
REQ-005 SHALL have parameter DropOnErr, default 1; 1 = discard frames ending with tuser[0]=1 (store-and-forward only).
REQ-006 SHALL have type parameters axis_req_t and axis_rsp_t, the shared AXI-Stream request/response structs (t.data, t.keep, t.last, t.user, tvalid; tready).
REQ-007 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-008 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-009 SHALL have ports s_axis_req_i  in  axis_req_t  and s_axis_rsp_o  out  axis_rsp_t  ingress stream.
REQ-010 SHALL have ports m_axis_req_o  out  axis_req_t  and m_axis_rsp_i  in  axis_rsp_t  egress stream.
REQ-011 SHALL have port fill_o  out  $clog2(Depth)+1  beats currently stored (wr_ptr - rd_ptr).
REQ-012 SHALL have port pkt_cnt_o  out  $clog2(Depth)+1  complete committed frames stored.
REQ-013 SHALL have port drop_cnt_o  out  16  frames discarded since reset, saturating at 16'hFFFF.

Function
REQ-014 SHALL store data, keep, last, user per beat in a Depth-entry array, using wr_ptr, commit_ptr, rd_ptr of $clog2(Depth)+1 bits with MSB wrap bit; full = fill==Depth, empty = fill==0.
REQ-015 SHALL drive s tready from registered state only (no path from m tready or s tvalid); tready=0 when full in ACCEPT.
REQ-016 SHALL implement write FSM states ACCEPT and DROP.
REQ-017 In ACCEPT, on s handshake SHALL write the beat at wr_ptr and increment wr_ptr.
REQ-018 On accepted tlast without drop SHALL set commit_ptr to wr_ptr+1 (i.e. after the tlast beat) and increment pkt_cnt.
REQ-019 With StoreForward=1, DropOnErr=1, accepted tlast with tuser[0]=1 SHALL reset wr_ptr to commit_ptr, not commit, increment drop_cnt.
REQ-020 With StoreForward=1, in ACCEPT when full and commit_ptr==rd_ptr (oversize frame fills FIFO) SHALL reset wr_ptr to commit_ptr and enter DROP; tready=0 that cycle.
REQ-021 In DROP SHALL assert tready=1, discard beats, and on accepted tlast return to ACCEPT and increment drop_cnt.
REQ-022 m tvalid SHALL be rd_ptr!=commit_ptr (StoreForward=1) or rd_ptr!=wr_ptr (StoreForward=0); m payload is array[rd_ptr] combinationally; m handshake increments rd_ptr.
REQ-023 Latency: cut-through, beat accepted in cycle N valid at m in N+1; store-forward, first beat valid in cycle after tlast accepted.
REQ-024 With StoreForward=0, DropOnErr and oversize rules SHALL be inert; commit_ptr tracks wr_ptr; tuser passes through unchanged.
REQ-025 Egress handshake with t.last SHALL decrement pkt_cnt; simultaneous commit and egress last SHALL leave pkt_cnt unchanged.
REQ-026 Simultaneous read and write when full: write blocked that cycle, read proceeds; when empty, write proceeds, no read.
REQ-027 m tvalid once asserted SHALL hold with stable payload until handshake (AXI-Stream rule).

Reset
REQ-028 rst_i=1 at a clock edge SHALL clear all pointers, pkt_cnt, drop_cnt, FSM to ACCEPT; outputs then: m tvalid=0, s tready=1, fill_o=0, pkt_cnt_o=0, drop_cnt_o=0.
REQ-029 Reset mid-frame SHALL discard all stored and partial frames without counting drops; array contents need not be cleared.

Structure
REQ-030 Default axis_req_t/axis_rsp_t and DataWidth/UserWidth SHALL come from eth_idma_pkg; drop counter width SHALL be a localparam in eth_idma_pkg.
REQ-031 Storage array SHALL be sub-module eth_axis_pkt_fifo_ram (1 write port, 1 async read port), replaceable by a macro.

Verification (Depth=8, DataWidth=64)
REQ-032 SF: 3-beat frame, data 1,2,3, m tready=1 -> m tvalid stays 0 until cycle after beat 3, then 1,2,3 out with last on 3; pkt_cnt 1->0.
REQ-033 SF, DropOnErr: 4-beat frame with tuser[0]=1 on last -> no m output, drop_cnt_o=1, fill_o=0.
REQ-034 SF: 10-beat frame into empty FIFO, m tready=0 -> tready low 1 cycle at fill 8, remaining 2 beats absorbed, drop_cnt_o=1, fill_o=0; next 2-beat frame forwarded intact.
REQ-035 Cut-through: beats A,B,C with m tready=0 for 5 cycles -> fill_o=3, m tvalid=1 from cycle after A, payload A stable; release outputs A,B,C.
REQ-036 SF: fill to 8 with two 4-beat frames, m tready toggling, continuous input -> no loss, order kept, tready never high when full, pointers wrap correctly.
REQ-037 rst_i asserted mid-frame with 5 beats stored -> next cycle fill_o=0, pkt_cnt_o=0, drop_cnt_o unchanged at 0, m tvalid=0.

Source files
------------

// File: rtl/eth_idma_pkg.sv
// Shared AXI-Stream types and widths for the Ethernet iDMA datapath.
// The packet FIFO and any neighbouring blocks take their default stream types from here.
package eth_idma_pkg;

    localparam int unsigned DataWidth    = 64;
    localparam int unsigned KeepWidth    = DataWidth / 8;
    localparam int unsigned UserWidth    = 1;
    localparam int unsigned DropCntWidth = 16;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [KeepWidth-1:0] keep;
        logic                 last;
        logic [UserWidth-1:0] user;
    } axis_t_t;

    typedef struct packed {
        axis_t_t t;
        logic    tvalid;
    } axis_req_t;

    typedef struct packed {
        logic tready;
    } axis_rsp_t;

    typedef enum logic {
        WR_ACCEPT = 1'b0,
        WR_DROP   = 1'b1
    } wr_state_e;

endpackage

// File: rtl/eth_axis_pkt_fifo_ram.sv
// Beat storage for the packet FIFO: one synchronous write port, one asynchronous read port.
// Kept separate so a technology macro can be swapped in without touching the FIFO control.
module eth_axis_pkt_fifo_ram #(
    parameter int unsigned Width     = 8,
    parameter int unsigned Depth     = 8,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/eth_axis_pkt_fifo.sv
// AXI-Stream packet FIFO with store-and-forward (frame commit, error/oversize drop) or cut-through mode.
// Ingress tready depends only on registered state; egress payload is read asynchronously at rd_ptr.
module eth_axis_pkt_fifo #(
    parameter int unsigned DataWidth    = eth_idma_pkg::DataWidth,
    parameter int unsigned UserWidth    = eth_idma_pkg::UserWidth,
    parameter int unsigned Depth        = 512,
    parameter int unsigned StoreForward = 1,
    parameter int unsigned DropOnErr    = 1,
    parameter type         axis_req_t   = eth_idma_pkg::axis_req_t,
    parameter type         axis_rsp_t   = eth_idma_pkg::axis_rsp_t
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  axis_req_t                              s_axis_req_i,
    output axis_rsp_t                              s_axis_rsp_o,
    output axis_req_t                              m_axis_req_o,
    input  axis_rsp_t                              m_axis_rsp_i,
    output logic [$clog2(Depth):0]                 fill_o,
    output logic [$clog2(Depth):0]                 pkt_cnt_o,
    output logic [eth_idma_pkg::DropCntWidth-1:0]  drop_cnt_o
);

    import eth_idma_pkg::*;

    localparam int unsigned AddrWidth  = $clog2(Depth);
    localparam int unsigned PtrWidth   = AddrWidth + 1;
    localparam int unsigned KeepWidth  = DataWidth / 8;
    localparam int unsigned EntryWidth = DataWidth + KeepWidth + 1 + UserWidth;

    typedef logic [PtrWidth-1:0] ptr_t;

    wr_state_e state_q, state_d;

    ptr_t wr_ptr_q, commit_ptr_q, rd_ptr_q;
    ptr_t commit_ptr, fill;
    ptr_t pkt_cnt_q;
    logic [DropCntWidth-1:0] drop_cnt_q;

    logic full, oversize, err_last;
    logic s_ready, s_hs, s_last;
    logic m_valid, m_hs, m_last;
    logic ram_we, wr_rewind, commit_inc, drop_inc;
    logic [EntryWidth-1:0] wdata, rdata;

    // In cut-through mode every written beat is immediately visible to the reader.
    assign commit_ptr = (StoreForward != 0) ? commit_ptr_q : wr_ptr_q;
    assign fill       = wr_ptr_q - rd_ptr_q;
    assign full       = (fill == ptr_t'(Depth));
    assign oversize   = (StoreForward != 0) && full && (commit_ptr_q == rd_ptr_q);
    assign err_last   = (StoreForward != 0) && (DropOnErr != 0) && s_axis_req_i.t.user[0];

    assign s_last  = s_axis_req_i.t.last;
    assign s_hs    = s_axis_req_i.tvalid && s_ready;
    assign m_valid = (rd_ptr_q != commit_ptr);
    assign m_last  = rdata[UserWidth];
    assign m_hs    = m_valid && m_axis_rsp_i.tready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WR_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_ACCEPT: if (oversize)       state_d = WR_DROP;
            WR_DROP:   if (s_hs && s_last) state_d = WR_ACCEPT;
            default:                       state_d = WR_ACCEPT;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        ram_we     = 1'b0;
        wr_rewind  = 1'b0;
        commit_inc = 1'b0;
        drop_inc   = 1'b0;
        case (state_q)
            WR_ACCEPT: begin
                // Oversize implies full, so tready is already low in that cycle.
                s_ready = !full;
                ram_we  = s_hs;
                if (s_hs && s_last) begin
                    if (err_last) begin
                        wr_rewind = 1'b1;
                        drop_inc  = 1'b1;
                    end else begin
                        commit_inc = 1'b1;
                    end
                end
                if (oversize) begin
                    wr_rewind = 1'b1;
                end
            end
            WR_DROP: begin
                s_ready  = 1'b1;
                drop_inc = s_hs && s_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (wr_rewind) begin
                wr_ptr_q <= commit_ptr_q;
            end else if (ram_we) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (commit_inc) begin
                commit_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (m_hs) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            case ({commit_inc, m_hs && m_last})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + ptr_t'(1);
                2'b01:   pkt_cnt_q <= pkt_cnt_q - ptr_t'(1);
                default: ;
            endcase
            if (drop_inc && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign wdata = {s_axis_req_i.t.data, s_axis_req_i.t.keep, s_axis_req_i.t.last, s_axis_req_i.t.user};

    eth_axis_pkt_fifo_ram #(
        .Width     (EntryWidth),
        .Depth     (Depth),
        .AddrWidth (AddrWidth)
    ) i_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AddrWidth-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q[AddrWidth-1:0]),
        .rdata_o (rdata)
    );

    always_comb begin
        m_axis_req_o        = '0;
        m_axis_req_o.tvalid = m_valid;
        {m_axis_req_o.t.data, m_axis_req_o.t.keep, m_axis_req_o.t.last, m_axis_req_o.t.user} = rdata;
        s_axis_rsp_o        = '0;
        s_axis_rsp_o.tready = s_ready;
    end

    assign fill_o     = fill;
    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_eth_axis_pkt_fifo.sv
// Directed bench for the packet FIFO: one store-and-forward and one cut-through instance, Depth 8.
// Per-cycle vector table plus hand-written sequences for back-pressure/wrap and mid-frame reset.
module tb_eth_axis_pkt_fifo;

    import eth_idma_pkg::*;

    logic clk = 1'b0;
    logic rst;

    axis_req_t sf_s_req, sf_m_req, ct_s_req, ct_m_req;
    axis_rsp_t sf_s_rsp, sf_m_rsp, ct_s_rsp, ct_m_rsp;
    logic [3:0]  sf_fill, sf_pkt, ct_fill, ct_pkt;
    logic [15:0] sf_drop, ct_drop;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eth_axis_pkt_fifo #(
        .DataWidth    (64),
        .UserWidth    (1),
        .Depth        (8),
        .StoreForward (1),
        .DropOnErr    (1),
        .axis_req_t   (axis_req_t),
        .axis_rsp_t   (axis_rsp_t)
    ) dut_sf (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_axis_req_i (sf_s_req),
        .s_axis_rsp_o (sf_s_rsp),
        .m_axis_req_o (sf_m_req),
        .m_axis_rsp_i (sf_m_rsp),
        .fill_o       (sf_fill),
        .pkt_cnt_o    (sf_pkt),
        .drop_cnt_o   (sf_drop)
    );

    eth_axis_pkt_fifo #(
        .DataWidth    (64),
        .UserWidth    (1),
        .Depth        (8),
        .StoreForward (0),
        .DropOnErr    (1),
        .axis_req_t   (axis_req_t),
        .axis_rsp_t   (axis_rsp_t)
    ) dut_ct (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_axis_req_i (ct_s_req),
        .s_axis_rsp_o (ct_s_rsp),
        .m_axis_req_o (ct_m_req),
        .m_axis_rsp_i (ct_m_rsp),
        .fill_o       (ct_fill),
        .pkt_cnt_o    (ct_pkt),
        .drop_cnt_o   (ct_drop)
    );

    typedef struct {
        bit          ct;
        bit          sv;
        logic [63:0] sd;
        bit          sl;
        bit          su;
        bit          mr;
        bit          e_sr;
        bit          e_mv;
        logic [63:0] e_md;
        bit          e_ml;
        bit          e_mu;
        int          e_fill;
        int          e_pkt;
        int          e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit ct, bit sv, logic [63:0] sd, bit sl, bit su, bit mr,
                                bit e_sr, bit e_mv, logic [63:0] e_md, bit e_ml, bit e_mu,
                                int e_fill, int e_pkt, int e_drop);
        vec_t v;
        v.ct = ct; v.sv = sv; v.sd = sd; v.sl = sl; v.su = su; v.mr = mr;
        v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml; v.e_mu = e_mu;
        v.e_fill = e_fill; v.e_pkt = e_pkt; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_sf(input bit sv, input logic [63:0] sd, input bit sl, input bit su, input bit mr);
        sf_s_req          = '0;
        sf_s_req.tvalid   = sv;
        sf_s_req.t.data   = sd;
        sf_s_req.t.keep   = '1;
        sf_s_req.t.last   = sl;
        sf_s_req.t.user   = su;
        sf_m_rsp.tready   = mr;
    endtask

    task automatic drive_ct(input bit sv, input logic [63:0] sd, input bit sl, input bit su, input bit mr);
        ct_s_req          = '0;
        ct_s_req.tvalid   = sv;
        ct_s_req.t.data   = sd;
        ct_s_req.t.keep   = '1;
        ct_s_req.t.last   = sl;
        ct_s_req.t.user   = su;
        ct_m_rsp.tready   = mr;
    endtask

    initial begin
        rst = 1'b1;
        drive_sf(0, 0, 0, 0, 1);
        drive_ct(0, 0, 0, 0, 1);

        // Store-and-forward: 3-beat frame, released only after its last beat.
        vecs.push_back(mk(0,1,64'h1,0,0,1, 1,0,0,0,0, 0,0,0));
        vecs.push_back(mk(0,1,64'h2,0,0,1, 1,0,0,0,0, 1,0,0));
        vecs.push_back(mk(0,1,64'h3,1,0,1, 1,0,0,0,0, 2,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,     1,1,64'h1,0,0, 3,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,     1,1,64'h2,0,0, 2,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,     1,1,64'h3,1,0, 1,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,     1,0,0,0,0, 0,0,0));
        // Errored 4-beat frame is discarded.
        vecs.push_back(mk(0,1,64'h10,0,0,1, 1,0,0,0,0, 0,0,0));
        vecs.push_back(mk(0,1,64'h11,0,0,1, 1,0,0,0,0, 1,0,0));
        vecs.push_back(mk(0,1,64'h12,0,0,1, 1,0,0,0,0, 2,0,0));
        vecs.push_back(mk(0,1,64'h13,1,1,1, 1,0,0,0,0, 3,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,      1,0,0,0,0, 0,0,1));
        // 10-beat oversize frame with egress stalled.
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0,1,64'h20 + 64'(k),0,0,0, 1,0,0,0,0, k,0,1));
        end
        vecs.push_back(mk(0,1,64'h28,0,0,0, 0,0,0,0,0, 8,0,1));
        vecs.push_back(mk(0,1,64'h28,0,0,0, 1,0,0,0,0, 0,0,1));
        vecs.push_back(mk(0,1,64'h29,1,0,0, 1,0,0,0,0, 0,0,1));
        vecs.push_back(mk(0,1,64'h30,0,0,1, 1,0,0,0,0, 0,0,2));
        vecs.push_back(mk(0,1,64'h31,1,0,1, 1,0,0,0,0, 1,0,2));
        vecs.push_back(mk(0,0,0,0,0,1,      1,1,64'h30,0,0, 2,1,2));
        vecs.push_back(mk(0,0,0,0,0,1,      1,1,64'h31,1,0, 1,1,2));
        vecs.push_back(mk(0,0,0,0,0,1,      1,0,0,0,0, 0,0,2));
        // Cut-through: A,B,C held under back-pressure, then released; errored frame passes.
        vecs.push_back(mk(1,1,64'hA,0,0,0, 1,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,1,64'hB,0,0,0, 1,1,64'hA,0,0, 1,0,0));
        vecs.push_back(mk(1,1,64'hC,1,0,0, 1,1,64'hA,0,0, 2,0,0));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(1,0,0,0,0,0, 1,1,64'hA,0,0, 3,1,0));
        end
        vecs.push_back(mk(1,0,0,0,0,1,     1,1,64'hA,0,0, 3,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,     1,1,64'hB,0,0, 2,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,     1,1,64'hC,1,0, 1,1,0));
        vecs.push_back(mk(1,1,64'hD,1,1,1, 1,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,     1,1,64'hD,1,1, 1,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,     1,0,0,0,0, 0,0,0));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_sf_ready", sf_s_rsp.tready, 1);
        check("rst_sf_valid", sf_m_req.tvalid, 0);
        check("rst_sf_fill",  sf_fill, 0);
        check("rst_sf_pkt",   sf_pkt, 0);
        check("rst_sf_drop",  sf_drop, 0);
        check("rst_ct_ready", ct_s_rsp.tready, 1);
        check("rst_ct_valid", ct_m_req.tvalid, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            logic        o_sr, o_mv, o_ml, o_mu;
            logic [63:0] o_md;
            logic [7:0]  o_mk;
            logic [3:0]  o_fill, o_pkt;
            logic [15:0] o_drop;
            if (vecs[i].ct) begin
                drive_ct(vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].su, vecs[i].mr);
                drive_sf(0, 0, 0, 0, 1);
            end else begin
                drive_sf(vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].su, vecs[i].mr);
                drive_ct(0, 0, 0, 0, 1);
            end
            @(negedge clk);
            if (vecs[i].ct) begin
                o_sr = ct_s_rsp.tready; o_mv = ct_m_req.tvalid; o_md = ct_m_req.t.data;
                o_ml = ct_m_req.t.last; o_mu = ct_m_req.t.user[0]; o_mk = ct_m_req.t.keep;
                o_fill = ct_fill; o_pkt = ct_pkt; o_drop = ct_drop;
            end else begin
                o_sr = sf_s_rsp.tready; o_mv = sf_m_req.tvalid; o_md = sf_m_req.t.data;
                o_ml = sf_m_req.t.last; o_mu = sf_m_req.t.user[0]; o_mk = sf_m_req.t.keep;
                o_fill = sf_fill; o_pkt = sf_pkt; o_drop = sf_drop;
            end
            check($sformatf("v%0d_s_ready", i), o_sr, vecs[i].e_sr);
            check($sformatf("v%0d_m_valid", i), o_mv, vecs[i].e_mv);
            if (vecs[i].e_mv) begin
                check($sformatf("v%0d_m_data", i), o_md, vecs[i].e_md);
                check($sformatf("v%0d_m_last", i), o_ml, vecs[i].e_ml);
                check($sformatf("v%0d_m_user", i), o_mu, vecs[i].e_mu);
                check($sformatf("v%0d_m_keep", i), o_mk, 8'hFF);
            end
            check($sformatf("v%0d_fill", i), o_fill, 64'(vecs[i].e_fill));
            check($sformatf("v%0d_pkt", i),  o_pkt,  64'(vecs[i].e_pkt));
            check($sformatf("v%0d_drop", i), o_drop, 64'(vecs[i].e_drop));
            @(posedge clk); #1;
        end
        drive_ct(0, 0, 0, 0, 1);

        // Four 4-beat frames streamed continuously with toggling egress ready.
        begin
            int          sent = 0;
            int          rcvd = 0;
            bit          saw_full = 0;
            bit          prev_stall = 0;
            logic [63:0] prev_data = '0;
            for (int cyc = 0; cyc < 300 && rcvd < 16; cyc++) begin
                drive_sf(sent < 16, 64'h100 + 64'(sent), (sent % 4) == 3, 0, (cyc % 2) == 0);
                @(negedge clk);
                if (sf_fill == 4'd8) begin
                    saw_full = 1;
                    check("full_ready_low", sf_s_rsp.tready, 0);
                end
                if (prev_stall) begin
                    check("hold_valid", sf_m_req.tvalid, 1);
                    check("hold_data", sf_m_req.t.data, prev_data);
                end
                if (sf_m_req.tvalid && sf_m_rsp.tready) begin
                    check("order_data", sf_m_req.t.data, 64'h100 + 64'(rcvd));
                    check("order_last", sf_m_req.t.last, (rcvd % 4) == 3);
                    rcvd++;
                end
                prev_stall = sf_m_req.tvalid && !sf_m_rsp.tready;
                prev_data  = sf_m_req.t.data;
                if (sf_s_req.tvalid && sf_s_rsp.tready) sent++;
                @(posedge clk); #1;
            end
            drive_sf(0, 0, 0, 0, 1);
            check("stream_rcvd", rcvd, 16);
            check("stream_saw_full", saw_full, 1);
            check("stream_end_fill", sf_fill, 0);
            check("stream_end_pkt", sf_pkt, 0);
        end

        // Reset with a committed frame and a partial frame stored.
        for (int k = 0; k < 5; k++) begin
            drive_sf(1, 64'h200 + 64'(k), k == 1, 0, 0);
            @(posedge clk); #1;
        end
        drive_sf(0, 0, 0, 0, 0);
        @(negedge clk);
        check("pre_rst_fill", sf_fill, 5);
        check("pre_rst_pkt", sf_pkt, 1);
        check("pre_rst_valid", sf_m_req.tvalid, 1);
        @(posedge clk); #1;
        drive_sf(1, 64'h205, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_sf(0, 0, 0, 0, 0);
        @(negedge clk);
        check("mid_rst_fill", sf_fill, 0);
        check("mid_rst_pkt", sf_pkt, 0);
        check("mid_rst_drop", sf_drop, 0);
        check("mid_rst_valid", sf_m_req.tvalid, 0);
        check("mid_rst_ready", sf_s_rsp.tready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
